// File: rtl/ebm_mdq.sv
// ebm_mdq: egress buffer manager with a metadata queue.
// Buffer IDs from eos metadata are queued. One read request per ID goes to
// data_cache, the returned words are forwarded downstream, and each packet
// is closed with a good/bad verdict. The optional wait-for-data timeout is
// enabled with the EBM_TIMEOUT_EN macro (disabled by default).
module ebm_mdq #(
  parameter int DATA_W    = 134,
  parameter int ID_W      = 8,
  parameter int MD_W      = 12,
  parameter int MDQ_DEPTH = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MD_W-1:0]   in_md,
  input  logic              in_md_wr,
  output logic              out_mdq_full,
  output logic [ID_W-1:0]   out_id,
  output logic              out_id_wr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_data_wr,
  input  logic              in_valid,
  input  logic              in_valid_wr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_data_wr,
  output logic              out_valid,
  output logic              out_valid_wr,
  output logic [31:0]       out_pkt_cnt,
  output logic [15:0]       out_md_drop_cnt,
  output logic [15:0]       out_to_cnt
);

  localparam int PTR_W = $clog2(MDQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MDQ_DEPTH);
  localparam logic [1:0] TYPE_HEAD = 2'b01;
  localparam logic [1:0] TYPE_TAIL = 2'b10;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, TRAN = 2'd2} state_t;

  state_t           state;
  logic [ID_W-1:0]  mem [MDQ_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             error;
  logic             push;
  logic             pop;
  logic [1:0]       word_type;
  logic             is_tail;
  logic             err_now;

  // Only the low ID_W metadata bits carry the buffer ID; the rest is ignored.
  generate
    if (MD_W > ID_W) begin : g_md_extra
      logic md_unused;
      assign md_unused = ^in_md[MD_W-1:ID_W];
    end
  endgenerate

  // Queue handshakes, word decode and the error flag as seen this cycle.
  always_comb begin
    push      = in_md_wr && (count != FULL_CNT);
    pop       = (state == IDLE) && (count != '0);
    word_type = in_data[DATA_W-1 -: 2];
    is_tail   = in_data_wr && (word_type == TYPE_TAIL);
    err_now   = error
              | (in_valid_wr & ~in_valid)
              | ((state == TRAN) && in_data_wr && (word_type == TYPE_HEAD));
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Queue storage; contents need no reset since the count marks validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_md[ID_W-1:0];
  end

  // Queue pointers, occupancy, registered full flag and drop statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      out_mdq_full    <= 1'b0;
      out_md_drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count        <= count_next;
      out_mdq_full <= (count_next == FULL_CNT);
      if (in_md_wr && !push && (out_md_drop_cnt != 16'hFFFF))
        out_md_drop_cnt <= out_md_drop_cnt + 16'd1;
    end
  end

`ifdef EBM_TIMEOUT_EN
  logic [15:0] to_cnt;
`else
  localparam int timeout_unused = TIMEOUT;
  assign out_to_cnt = '0;
`endif

  // Packet FSM: issues ID requests, forwards words and emits verdicts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      error        <= 1'b0;
      out_id       <= '0;
      out_id_wr    <= 1'b0;
      out_data     <= '0;
      out_data_wr  <= 1'b0;
      out_valid    <= 1'b0;
      out_valid_wr <= 1'b0;
      out_pkt_cnt  <= '0;
`ifdef EBM_TIMEOUT_EN
      to_cnt       <= '0;
      out_to_cnt   <= '0;
`endif
    end else begin
      out_id_wr    <= 1'b0;
      out_data     <= '0;
      out_data_wr  <= 1'b0;
      out_valid    <= 1'b0;
      out_valid_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            out_id    <= mem[rd_ptr];
            out_id_wr <= 1'b1;
            error     <= 1'b0;
            state     <= WAIT;
`ifdef EBM_TIMEOUT_EN
            to_cnt    <= '0;
`endif
          end
        end
        WAIT, TRAN: begin
          error <= err_now;
          if (in_data_wr) begin
            out_data    <= in_data;
            out_data_wr <= 1'b1;
            if (is_tail) begin
              out_valid_wr <= 1'b1;
              out_valid    <= ~err_now;
              if (!err_now) out_pkt_cnt <= out_pkt_cnt + 32'd1;
              state <= IDLE;
            end else begin
              state <= TRAN;
            end
          end
`ifdef EBM_TIMEOUT_EN
          else if (state == WAIT) begin
            if (to_cnt == 16'(TIMEOUT - 1)) begin
              out_valid_wr <= 1'b1;
              out_valid    <= 1'b0;
              if (out_to_cnt != 16'hFFFF) out_to_cnt <= out_to_cnt + 16'd1;
              state <= IDLE;
            end else begin
              to_cnt <= to_cnt + 16'd1;
            end
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
